// File: rtl/mult8_seq_share_ctrl.sv
// Sequential 8x8 unsigned multiplier sharing one external combinational 4x4 multiplier over four nibble steps.
// Optional MULT8_ZERO_SKIP_EN: steps whose nibble pair contains a zero are skipped.
module mult8_seq_share_ctrl #(
  parameter int HALF  = 4,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*HALF-1:0]   in_a,
  input  logic [2*HALF-1:0]   in_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*HALF-1:0]   out_p,
  output logic [HALF-1:0]     m_a,
  output logic [HALF-1:0]     m_b,
  input  logic [2*HALF-1:0]   m_p,
  output logic                busy,
  output logic [CNT_W-1:0]    op_count
);

  typedef enum logic [2:0] {IDLE, S_LL, S_LH, S_HL, S_HH, DONE} state_t;

  state_t              state, state_nx;
  logic [2*HALF-1:0]   a_q, b_q;
  logic [4*HALF-1:0]   acc, acc_add, mp_ext;
  logic [3:0]          mask_in, mask;
  logic                accept, deliver;

  assign accept  = (state == IDLE) && in_valid;
  assign deliver = (state == DONE) && out_ready;
  assign mp_ext  = {{(2*HALF){1'b0}}, m_p};
  assign out_p   = (state == DONE) ? acc : '0;

`ifdef MULT8_ZERO_SKIP_EN
  // Bit order matches the visiting order: [0]=LL [1]=LH [2]=HL [3]=HH.
  assign mask_in = {(|in_a[2*HALF-1:HALF]) && (|in_b[2*HALF-1:HALF]),
                    (|in_a[2*HALF-1:HALF]) && (|in_b[HALF-1:0]),
                    (|in_a[HALF-1:0])      && (|in_b[2*HALF-1:HALF]),
                    (|in_a[HALF-1:0])      && (|in_b[HALF-1:0])};

  always_ff @(posedge clk) begin
    if (rst) begin
      mask <= '0;
    end else if (accept) begin
      mask <= mask_in;
    end
  end
`else
  assign mask_in = 4'hF;
  assign mask    = 4'hF;
`endif

  // First required step in visiting order, or DONE when none remain.
  function automatic state_t pick(input logic [3:0] m);
    if (m[0])      return S_LL;
    else if (m[1]) return S_LH;
    else if (m[2]) return S_HL;
    else if (m[3]) return S_HH;
    else           return DONE;
  endfunction

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    m_a       = '0;
    m_b       = '0;
    acc_add   = '0;
    case (state)
      IDLE: begin
        busy     = 1'b0;
        in_ready = 1'b1;
        if (in_valid) state_nx = pick(mask_in);
      end
      S_LL: begin
        m_a      = a_q[HALF-1:0];
        m_b      = b_q[HALF-1:0];
        acc_add  = mp_ext;
        state_nx = pick(mask & 4'b1110);
      end
      S_LH: begin
        m_a      = a_q[HALF-1:0];
        m_b      = b_q[2*HALF-1:HALF];
        acc_add  = mp_ext << HALF;
        state_nx = pick(mask & 4'b1100);
      end
      S_HL: begin
        m_a      = a_q[2*HALF-1:HALF];
        m_b      = b_q[HALF-1:0];
        acc_add  = mp_ext << HALF;
        state_nx = pick(mask & 4'b1000);
      end
      S_HH: begin
        m_a      = a_q[2*HALF-1:HALF];
        m_b      = b_q[2*HALF-1:HALF];
        acc_add  = mp_ext << (2*HALF);
        state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      op_count <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_q <= in_a;
        b_q <= in_b;
        acc <= '0;
      end else begin
        acc <= acc + acc_add;
      end
      if (deliver) op_count <= op_count + CNT_W'(1);
    end
  end

endmodule

// File: doc/mult8_seq_share_ctrl.md
Name: mult8_seq_share_ctrl

Overview:
Multi-cycle 8x8 unsigned multiplier controller that time-shares one external combinational 4x4 multiplier (any mult4_* variant) across the four nibble partial products LL, LH, HL, HH.
- Valid/ready handshake on input and output; 16-bit accumulator holds the product.
- Used where area matters more than throughput: one mult4 instead of four.
- Also keeps a completed-operation counter for bench and debug visibility.

Parameters:
HALF, 4, nibble width; operands are 2*HALF bits, product and accumulator are 4*HALF bits.
CNT_W, 16, width of the completed-operation counter.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  controller can accept operands
in_a  input  8  multiplicand A, unsigned
in_b  input  8  multiplier B, unsigned
out_valid  output  1  product valid
out_ready  input  1  consumer accepts product
out_p  output  16  product A*B
m_a  output  4  operand A nibble to shared mult4
m_b  output  4  operand B nibble to shared mult4
m_p  input  8  combinational result from shared mult4 (m_a*m_b, same cycle)
busy  output  1  high in any state other than IDLE
op_count  output  CNT_W  number of completed output handshakes

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state IDLE, in_ready=1, out_valid=0, out_p=0, busy=0, op_count=0, m_a=0, m_b=0, accumulator=0.
- States: IDLE, S_LL, S_LH, S_HL, S_HH, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: register in_a and in_b, clear accumulator, go to S_LL.
  - Operands are never sampled outside this handshake.
- Compute states drive m_a/m_b combinationally from the registered operands:
  - S_LL: A[3:0], B[3:0]; acc += m_p.
  - S_LH: A[3:0], B[7:4]; acc += m_p<<4.
  - S_HL: A[7:4], B[3:0]; acc += m_p<<4.
  - S_HH: A[7:4], B[7:4]; acc += m_p<<8.
  - Sequence is LL -> LH -> HL -> HH -> DONE, one state per cycle.
  - In IDLE and DONE, m_a=m_b=0.
- Arithmetic: accumulate in 16 bits, zero-extend m_p before shifting. The exact product never exceeds 0xFE01, so no overflow handling is needed.
- DONE:
  - out_valid=1 and out_p=accumulator.
  - Holds stable until out_ready; on out_valid&&out_ready go to IDLE and op_count++ (wraps at 2^CNT_W).
- Latency: operands accepted at cycle 0; out_valid first asserted at cycle 5 (rising edge after S_HH).
- Throughput: one product per 6 cycles with out_ready tied high. in_ready is 0 from S_LL until the cycle after the output handshake; no overlap and no input buffering.
- Back-pressure: while out_valid=1 and out_ready=0, out_p, state and op_count hold. in_valid is ignored.
- Reset mid-operation: rst wins over every transition. Next cycle is IDLE with reset values; the in-flight product is discarded and not counted.
- in_valid deassertion during compute has no effect. Operands change while busy are ignored.

Optional Feature:
Macro MULT8_ZERO_SKIP_EN.
- Defined: on acceptance, compute a 4-bit step mask; a step is required iff both of its nibbles are nonzero.
  - The FSM visits only required steps in the order LL, LH, HL, HH, then DONE.
  - From IDLE, go to the first required step, or directly to DONE if none (acc=0).
  - Latency = 1 + number of required steps (range 1..5).
  - Skipped steps do not drive m_a/m_b (held 0).
- Not defined: fixed 4-step sequence, latency always 5. Mask logic is absent.

Test Plan:
- A=0xFF, B=0xFF, out_ready=1 -> out_valid at cycle 5, out_p=0xFE01; op_count=1.
- A=0x12, B=0x34 -> m_a/m_b sequence (2,4),(2,3),(1,4),(1,3) on cycles 1-4; out_p=0x03A8.
- A=0x0F, B=0xF0, out_ready held 0 for 3 cycles after out_valid -> out_p=0x0E10 held stable, in_ready=0 throughout, in_valid pulses ignored; handshake then returns to IDLE.
- rst asserted in S_HL of A=0xAB, B=0xCD -> next cycle IDLE, out_valid=0, op_count unchanged. A new operation A=0x03, B=0x05 then yields 0x000F.
- Back-to-back 10 random operations with in_valid high and out_ready=1 -> each result equals A*B, op_count=10, spacing 6 cycles.
- MULT8_ZERO_SKIP_EN:
  - A=0x0F, B=0xF0 -> only S_LH executes, out_valid at cycle 2, out_p=0x0E10.
  - A=0x00, B=0x5A -> out_valid at cycle 1, out_p=0.
